// File: rtl/ssd_scan_sched_if.sv
// rtl/ssd_scan_sched_if.sv - scan scheduler control/status bundle
// blink_mask exists only when BLINK_EN is defined.
interface ssd_scan_sched_if;
   logic       en;
   logic [3:0] digit_en;
   logic       lz_blank;
   logic [3:0] in1;
   logic [3:0] in2;
   logic [3:0] in3;
`ifdef BLINK_EN
   logic [3:0] blink_mask;
`endif
   logic [1:0] sel;
   logic       blank;
   logic       frame_done;

`ifdef BLINK_EN
   modport master (output en, digit_en, lz_blank, in1, in2, in3, blink_mask,
                   input  sel, blank, frame_done);
   modport slave  (input  en, digit_en, lz_blank, in1, in2, in3, blink_mask,
                   output sel, blank, frame_done);
`else
   modport master (output en, digit_en, lz_blank, in1, in2, in3,
                   input  sel, blank, frame_done);
   modport slave  (input  en, digit_en, lz_blank, in1, in2, in3,
                   output sel, blank, frame_done);
`endif
endinterface

// File: rtl/ssd_scan_sched.sv
// rtl/ssd_scan_sched.sv - digit scan scheduler with dead time for a 4-digit 7-seg display
// Optional BLINK_EN macro adds per-digit blinking driven by a frame counter.
module ssd_scan_sched #(
   parameter int DIV_WIDTH    = 16,
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYC     = 8,
   parameter int BLINK_FRAMES = 250
) (
   input logic             clk,
   input logic             rst,
   ssd_scan_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ON, DEAD} state_t;

   localparam logic [DIV_WIDTH-1:0] DWELL_LAST = DIV_WIDTH'(SCAN_DIV - 1);
   localparam logic [7:0]           DEAD_LAST  = 8'(DEAD_CYC - 1);

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] dwell_q, dwell_d;
   logic [7:0]           dead_q, dead_d;
   logic [1:0]           sel_q, sel_d;
   logic                 blank_q, blank_d;
   logic                 fd_q, fd_d;
   logic [3:0]           lz;
   logic [3:0]           vis;
   logic [3:0]           blink_hide;
   logic [1:0]           next_idx, low_idx, cand;

   // Leading zeros ripple down from digit 3; digit 0 always shows.
   always_comb begin
      lz    = 4'b0000;
      lz[3] = bus.lz_blank && (bus.in3 == 4'd0);
      lz[2] = lz[3] && (bus.in2 == 4'd0);
      lz[1] = lz[2] && (bus.in1 == 4'd0);
      vis   = bus.digit_en & ~lz & ~blink_hide;
   end

   always_comb begin
      next_idx = sel_q;
      cand     = sel_q;
      for (int k = 3; k >= 1; k--) begin
         cand = sel_q + 2'(k);
         if (bus.digit_en[cand]) next_idx = cand;
      end
      low_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (bus.digit_en[k]) low_idx = 2'(k);
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      dwell_d = dwell_q;
      dead_d  = dead_q;
      fd_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.en) begin
               state_d = ON;
               sel_d   = low_idx;
            end
         end
         ON: begin
            if (dwell_q == DWELL_LAST) begin
               state_d = DEAD;
               dwell_d = '0;
               dead_d  = '0;
               sel_d   = next_idx;
               fd_d    = (|bus.digit_en) && (next_idx <= sel_q);
            end else begin
               dwell_d = dwell_q + DIV_WIDTH'(1);
            end
         end
         DEAD: begin
            if (dead_q == DEAD_LAST) begin
               state_d = ON;
               dead_d  = '0;
               dwell_d = '0;
            end else begin
               dead_d = dead_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!bus.en) begin
         state_d = IDLE;
         sel_d   = 2'd0;
         dwell_d = '0;
         dead_d  = '0;
         fd_d    = 1'b0;
      end
      blank_d = !((state_d == ON) && vis[sel_d]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         blank_q <= 1'b1;
         fd_q    <= 1'b0;
         dwell_q <= '0;
         dead_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         blank_q <= blank_d;
         fd_q    <= fd_d;
         dwell_q <= dwell_d;
         dead_q  <= dead_d;
      end
   end

`ifdef BLINK_EN
   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               phase_q, phase_d;

   always_comb begin
      frame_d = frame_q;
      phase_d = phase_q;
      if (state_d == IDLE) begin
         frame_d = '0;
         phase_d = 1'b0;
      end else if (fd_d) begin
         if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_d = '0;
            phase_d = ~phase_q;
         end else begin
            frame_d = frame_q + FRAME_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q <= '0;
         phase_q <= 1'b0;
      end else begin
         frame_q <= frame_d;
         phase_q <= phase_d;
      end
   end

   assign blink_hide = phase_q ? bus.blink_mask : 4'b0000;
`else
   assign blink_hide = 4'(BLINK_FRAMES) & 4'b0000;
`endif

   assign bus.sel        = sel_q;
   assign bus.blank      = blank_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_ssd_scan_sched.sv
// tb/tb_ssd_scan_sched.sv - scoreboard bench for ssd_scan_sched
// Stimulus queues per-cycle {sel,blank,frame_done}; a negedge monitor pops and compares.
module tb_ssd_scan_sched;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ssd_scan_sched_if bus();

   ssd_scan_sched #(
      .DIV_WIDTH(16), .SCAN_DIV(4), .DEAD_CYC(2), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [3:0] exp_q[$];
   logic [3:0] mon_e;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_seen  = 0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_tests++;
         if ({bus.sel, bus.blank, bus.frame_done} !== mon_e) begin
            n_fail++;
            $display("FAIL trace[%0d] sel/blank/frame_done got %0d/%b/%b exp %0d/%b/%b",
                     n_seen, bus.sel, bus.blank, bus.frame_done,
                     mon_e[3:2], mon_e[1], mon_e[0]);
         end
         n_seen++;
      end
   end

   task automatic push(input logic [1:0] s, input logic b, input logic f, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({s, b, f});
   endtask

   // DEAD (2 cycles, blanked) followed by ON (4 cycles) for digit s
   task automatic digit(input logic [1:0] s, input logic b_on);
      push(s, 1'b1, 1'b0, 2);
      push(s, b_on, 1'b0, 4);
   endtask

   task automatic wrap(input logic [1:0] s, input logic b_on);
      push(s, 1'b1, 1'b1, 1);
      push(s, 1'b1, 1'b0, 1);
      push(s, b_on, 1'b0, 4);
   endtask

   task automatic drain;
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout left=%0d exp 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic chk(input string name, input int got, input int expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s got %0d exp %0d", name, got, expv);
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.digit_en = 4'hF;
      bus.lz_blank = 1'b0;
      bus.in1      = 4'd0;
      bus.in2      = 4'd0;
      bus.in3      = 4'd0;
`ifdef BLINK_EN
      bus.blink_mask = 4'b0000;
`endif
      @(negedge clk);
      #1;
      push(2'd0, 1'b1, 1'b0, 2);
      drain;

      // full scan of all four digits, two frames
      rst    = 1'b0;
      bus.en = 1'b1;
      push(2'd0, 1'b0, 1'b0, 4);
      repeat (2) begin
         digit(2'd1, 1'b0); digit(2'd2, 1'b0); digit(2'd3, 1'b0); wrap(2'd0, 1'b0);
      end
      drain;

      bus.digit_en = 4'b0101;
      repeat (2) begin
         digit(2'd2, 1'b0); wrap(2'd0, 1'b0);
      end
      drain;

      // leading-zero blanking of digits 3 and 2
      bus.digit_en = 4'hF;
      bus.lz_blank = 1'b1;
      bus.in1      = 4'd7;
      digit(2'd1, 1'b0); digit(2'd2, 1'b1); digit(2'd3, 1'b1); wrap(2'd0, 1'b0);
      digit(2'd1, 1'b0);
      push(2'd2, 1'b1, 1'b0, 4);
      drain;
      bus.in3 = 4'd5;
      push(2'd2, 1'b0, 1'b0, 1);
      drain;

      bus.en = 1'b0;
      push(2'd0, 1'b1, 1'b0, 3);
      drain;

      bus.en       = 1'b1;
      bus.digit_en = 4'b1000;
      push(2'd3, 1'b0, 1'b0, 4);
      repeat (2) wrap(2'd3, 1'b0);
      drain;

      // no digit enabled: sequence runs, sel held, always blank, no frame_done
      bus.digit_en = 4'b0000;
      push(2'd3, 1'b1, 1'b0, 8);
      drain;

      bus.digit_en = 4'b1000;
      push(2'd3, 1'b0, 1'b0, 4);
      push(2'd3, 1'b1, 1'b1, 1);
      drain;

      // asynchronous reset in the first DEAD cycle, checked before the next edge
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_sel", int'(bus.sel), 0);
      chk("async_rst_blank", int'(bus.blank), 1);
      chk("async_rst_frame_done", int'(bus.frame_done), 0);
      @(negedge clk);
      #1;
      push(2'd0, 1'b1, 1'b0, 2);
      drain;

`ifdef BLINK_EN
      bus.digit_en   = 4'hF;
      bus.lz_blank   = 1'b0;
      bus.blink_mask = 4'b0001;
      rst            = 1'b0;
      push(2'd0, 1'b0, 1'b0, 4);
      for (int f = 0; f < 4; f++) begin
         digit(2'd1, 1'b0); digit(2'd2, 1'b0); digit(2'd3, 1'b0);
         wrap(2'd0, (f == 1 || f == 2));
      end
      drain;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
